line_compactor: RTL and testbench
=================================

LINE_COMPACTOR -- requirements
Module: line_compactor

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DATA_W, 8, grid cell width in bits; a cell equal to 0 is air.
- ADDR_W, 8, grid memory address width.
- LINE_WIDTH, 10, cells per line.
- NUM_LINES, 20, lines in the playfield.
- LINE_STRIDE, 12, address distance between vertically adjacent lines.
- BASE_ADDR, 1, address of row 0, col 0. Row 0 is the top line.
REQ-002 CNT_W SHALL be the localparam ceil(log2(NUM_LINES+1)).
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle request to scan and compact the grid.
- data_in, in, DATA_W, grid read data; valid the cycle after addr is presented.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle completion pulse.
- lines_cleared, out, CNT_W, full lines removed by the last operation.
- we, out, 1, grid write enable.
- addr, out, ADDR_W, grid address.
- data_out, out, DATA_W, grid write data.
- score, out, 16, accumulated score (see Configuration).

Function
REQ-004 Cell (r,c) SHALL be at address BASE_ADDR + r*LINE_STRIDE + c, computed modulo 2^ADDR_W.
REQ-005 The FSM states SHALL be IDLE, CHECK, COPY, FILL and DONE.
REQ-006 IDLE: start=1 SHALL load src=dst=NUM_LINES-1 and count=0, then go to CHECK. start SHALL be ignored in every other state.
REQ-007 CHECK SHALL read cells (src,0..LINE_WIDTH-1) on consecutive cycles, pipelined, and count non-zero data_in; it SHALL occupy LINE_WIDTH+1 cycles.
REQ-008 After CHECK, a full line (count == LINE_WIDTH) SHALL increment lines_cleared-in-progress and decrement src only.
REQ-009 After CHECK, a non-full line with src==dst SHALL decrement src and dst with no memory writes.
REQ-010 After CHECK, a non-full line with src!=dst SHALL go to COPY.
REQ-011 COPY SHALL take 2 cycles per cell: read (src,c), then write data_in to (dst,c) with we=1. After the last cell, src and dst SHALL both decrement and the FSM SHALL return to CHECK.
REQ-012 When src has passed row 0, the FSM SHALL go to FILL if dst is at or above row 0, otherwise to DONE.
REQ-013 FILL SHALL write 0 to every cell of rows dst down to 0 (all rows above the last compacted row), one cell per cycle with we=1.
REQ-014 DONE SHALL hold for one cycle with done=1, register lines_cleared, and return to IDLE.
REQ-015 we SHALL be high only in COPY write cycles and FILL cycles. addr SHALL be 0 in IDLE and DONE. data_out SHALL be 0 except in COPY write cycles.
REQ-016 An all-full grid SHALL give lines_cleared=NUM_LINES with every row zero-filled. An empty grid SHALL give lines_cleared=0 with zero writes.
REQ-017 lines_cleared SHALL hold its value until the next DONE.

Reset
REQ-018 rst=1 SHALL immediately force IDLE, with busy=done=we=0, addr=data_out=0, lines_cleared=0 and score=0.
REQ-019 A reset during an operation SHALL abandon it. Grid contents are then undefined and no done pulse SHALL be issued.

Configuration
REQ-020 With LINE_CLEAR_SCORE_EN defined, each DONE SHALL add lines_cleared*lines_cleared to score, saturating at 16'hFFFF.
REQ-021 Without LINE_CLEAR_SCORE_EN, score SHALL be constant 0 and no score logic SHALL be synthesised.

Verification (default parameters)
REQ-022 The bench SHALL cover these directed scenarios:
- Empty grid, start -> done after 20*11 CHECK cycles, lines_cleared=0, we never asserted.
- Row 19 full, row 18 has one cell =3 at col 2 -> lines_cleared=1; addr 1+19*12+2=231 holds 3; row 0 all 0.
- Rows 17 and 19 full, rows 16 and 18 distinct patterns -> lines_cleared=2; row 19 = old 18; row 18 = old 16; rows 0-1 all 0.
- All 20 rows full -> lines_cleared=20; all 200 cells 0. With LINE_CLEAR_SCORE_EN, score=400.
- rst asserted mid-COPY -> busy, we and addr are 0 in the same cycle; no done pulse; a following start completes normally.
- start pulsed while busy -> ignored; exactly one done pulse is produced.

Source files
------------

// File: rtl/line_compactor.sv
`default_nettype none
// ============================================================================
//  Module   : line_compactor
//  Purpose  : Scans a line-based playfield held in external grid memory from
//             the bottom row upward, removes every full line, shifts the
//             remaining lines down and zero-fills the vacated rows at the top.
//  Options  : LINE_CLEAR_SCORE_EN - when defined, accumulates a saturating
//             score of lines_cleared^2 per completed operation.
//  Revision : 1.0 - initial release
// ============================================================================
module line_compactor #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int LINE_WIDTH  = 10,
  parameter int NUM_LINES   = 20,
  parameter int LINE_STRIDE = 12,
  parameter int BASE_ADDR   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [DATA_W-1:0]              data_in,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_LINES+1)-1:0] lines_cleared,
  output logic                           we,
  output logic [ADDR_W-1:0]              addr,
  output logic [DATA_W-1:0]              data_out,
  output logic [15:0]                    score
);

  localparam int CNT_W = $clog2(NUM_LINES+1);
  // Row indices carry one extra MSB so "passed row 0" shows up as a set sign bit.
  localparam int ROW_W = $clog2(NUM_LINES) + 1;
  localparam int COL_W = $clog2(LINE_WIDTH+1);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_LINES-1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH-1);
  localparam logic [COL_W-1:0] FULL_CNT = COL_W'(LINE_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_COPY  = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   src_q, src_d;
  logic [ROW_W-1:0]   dst_q, dst_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [COL_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic [CNT_W-1:0]   lines_q, lines_d;
  logic [CNT_W-1:0]   lines_cleared_q;

  logic [ROW_W-1:0]   row_sel;
  logic [COL_W-1:0]   col_sel;
  logic               addr_en;
  logic               row_done;
  logic [COL_W-1:0]   cnt_now;

  // Occupied-cell count including the cell arriving this cycle.
  assign cnt_now = cnt_q + COL_W'(data_in != '0);

  // Next-state, datapath updates and memory-port outputs.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    lines_d  = lines_q;
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    we       = 1'b0;
    data_out = '0;
    row_sel  = '0;
    col_sel  = '0;
    addr_en  = 1'b0;
    row_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = LAST_ROW;
          dst_d   = LAST_ROW;
          lines_d = '0;
          col_d   = '0;
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        // Reads issue for columns 0..W-1; data lags one cycle, hence W+1 cycles.
        row_sel = src_q;
        col_sel = col_q;
        addr_en = (col_q != FULL_CNT);
        if (col_q != '0) begin
          cnt_d = cnt_now;
        end
        col_d = col_q + COL_W'(1);
        if (col_q == FULL_CNT) begin
          col_d = '0;
          cnt_d = '0;
          if (cnt_now == FULL_CNT) begin
            lines_d  = lines_q + CNT_W'(1);
            src_d    = src_q - ROW_W'(1);
            row_done = 1'b1;
          end else if (src_q == dst_q) begin
            src_d    = src_q - ROW_W'(1);
            dst_d    = dst_q - ROW_W'(1);
            row_done = 1'b1;
          end else begin
            phase_d = 1'b0;
            state_d = S_COPY;
          end
        end
      end

      S_COPY: begin
        addr_en = 1'b1;
        col_sel = col_q;
        if (!phase_q) begin
          row_sel = src_q;
          phase_d = 1'b1;
        end else begin
          row_sel  = dst_q;
          we       = 1'b1;
          data_out = data_in;
          phase_d  = 1'b0;
          col_d    = col_q + COL_W'(1);
          if (col_q == LAST_COL) begin
            col_d    = '0;
            src_d    = src_q - ROW_W'(1);
            dst_d    = dst_q - ROW_W'(1);
            row_done = 1'b1;
          end
        end
      end

      S_FILL: begin
        addr_en = 1'b1;
        row_sel = dst_q;
        col_sel = col_q;
        we      = 1'b1;
        col_d   = col_q + COL_W'(1);
        if (col_q == LAST_COL) begin
          col_d = '0;
          dst_d = dst_q - ROW_W'(1);
          if (dst_q == '0) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // After finishing a row: keep scanning, or clear leftover top rows, or finish.
    if (row_done) begin
      if (src_d[ROW_W-1]) begin
        state_d = dst_d[ROW_W-1] ? S_DONE : S_FILL;
      end else begin
        state_d = S_CHECK;
      end
    end
  end

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign addr = addr_en ? (ADDR_W'(BASE_ADDR)
                           + ADDR_W'(row_sel) * ADDR_W'(LINE_STRIDE)
                           + ADDR_W'(col_sel))
                        : '0;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      lines_q <= lines_d;
    end
  end

  // Publish the result once per operation; it holds until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lines_cleared_q <= '0;
    end else if (state_q == S_DONE) begin
      lines_cleared_q <= lines_q;
    end
  end

  assign lines_cleared = lines_cleared_q;

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_q;
  logic [31:0] score_sum;

  assign score_sum = 32'(score_q) + 32'(lines_q) * 32'(lines_q);

  // Saturating score accumulation at each completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
    end else if (state_q == S_DONE) begin
      score_q <= (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[15:0];
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_compactor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_compactor
//  Purpose  : Directed self-checking bench for line_compactor with a
//             one-cycle-latency grid memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_line_compactor;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  data_in;
  logic        busy;
  logic        done;
  logic [4:0]  lines_cleared;
  logic        we;
  logic [7:0]  addr;
  logic [7:0]  data_out;
  logic [15:0] score;

  logic [7:0]  mem      [0:255];
  logic [7:0]  init_img [0:255];
  logic        load = 1'b0;

  int checks   = 0;
  int errors   = 0;
  int we_cnt   = 0;
  int done_cnt = 0;

`ifdef LINE_CLEAR_SCORE_EN
  localparam logic [15:0] EXP_FULL_SCORE = 16'd400;
`else
  localparam logic [15:0] EXP_FULL_SCORE = 16'd0;
`endif

  line_compactor dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .data_in      (data_in),
    .busy         (busy),
    .done         (done),
    .lines_cleared(lines_cleared),
    .we           (we),
    .addr         (addr),
    .data_out     (data_out),
    .score        (score)
  );

  always #5 clk = ~clk;

  // Grid memory: registered read, write on we; load copies the bench image.
  always @(posedge clk) begin
    data_in <= mem[addr];
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] = init_img[i];
    end else if (we) begin
      mem[addr] = data_out;
    end
  end

  // Event counters for writes and done pulses.
  always @(posedge clk) begin
    if (we)   we_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int caddr(input int r, input int c);
    return 1 + r * 12 + c;
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 256; i++) init_img[i] = 8'h00;
  endtask

  task automatic fill_row(input int r);
    for (int c = 0; c < 10; c++) init_img[caddr(r, c)] = 8'h80 + 8'(r);
  endtask

  task automatic commit_img();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic load_one_line();
    clear_img();
    fill_row(19);
    init_img[caddr(18, 2)] = 8'd3;
    commit_img();
  endtask

  task automatic run_op(output int cyc, output bit tmo, output bit busy1);
    @(negedge clk);
    we_cnt = 0; done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    busy1 = busy;
    tmo   = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (done) begin tmo = 1'b0; break; end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_img();
    commit_img();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", we); end
    checks++; if (addr !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr); end
    checks++; if (data_out !== 8'd0) begin errors++; $display("FAIL reset_data_out got %0d want 0", data_out); end
    checks++; if (lines_cleared !== 5'd0) begin errors++; $display("FAIL reset_lines got %0d want 0", lines_cleared); end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_empty_grid();
    int cyc; bit tmo; bit b1;
    clear_img();
    commit_img();
    run_op(cyc, tmo, b1);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL empty_timeout got %0b want 0", tmo); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL empty_busy got %0b want 1", b1); end
    checks++; if (cyc !== 221) begin errors++; $display("FAIL empty_latency got %0d want 221", cyc); end
    checks++; if (lines_cleared !== 5'd0) begin errors++; $display("FAIL empty_lines got %0d want 0", lines_cleared); end
    @(negedge clk);
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL empty_writes got %0d want 0", we_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL empty_done_pulses got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy_after got %0b want 0", busy); end
  endtask

  task automatic test_one_line();
    int cyc; bit tmo; bit b1; int bad;
    load_one_line();
    run_op(cyc, tmo, b1);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL one_timeout got %0b want 0", tmo); end
    @(negedge clk);
    checks++; if (lines_cleared !== 5'd1) begin errors++; $display("FAIL one_lines got %0d want 1", lines_cleared); end
    checks++; if (mem[231] !== 8'd3) begin errors++; $display("FAIL one_cell231 got %0d want 3", mem[231]); end
    checks++; if (mem[caddr(18, 2)] !== 8'd0) begin errors++; $display("FAIL one_row18 got %0d want 0", mem[caddr(18, 2)]); end
    bad = 0;
    for (int c = 0; c < 10; c++) if (mem[caddr(0, c)] !== 8'd0 || mem[caddr(19, c)] !== ((c == 2) ? 8'd3 : 8'd0)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL one_rows_0_19 got %0d bad cells want 0", bad); end
    checks++; if (we_cnt !== 200) begin errors++; $display("FAIL one_writes got %0d want 200", we_cnt); end
    repeat (5) @(negedge clk);
    checks++; if (lines_cleared !== 5'd1) begin errors++; $display("FAIL one_lines_hold got %0d want 1", lines_cleared); end
  endtask

  task automatic test_two_lines();
    int cyc; bit tmo; bit b1; int bad;
    clear_img();
    fill_row(19);
    fill_row(17);
    for (int c = 0; c < 10; c++) begin
      init_img[caddr(18, c)] = (c % 2 == 1) ? 8'h40 + 8'(c) : 8'h00;
      init_img[caddr(16, c)] = (c != 9) ? 8'h60 + 8'(c) : 8'h00;
    end
    init_img[caddr(0, 5)] = 8'd7;
    commit_img();
    run_op(cyc, tmo, b1);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL two_timeout got %0b want 0", tmo); end
    @(negedge clk);
    checks++; if (lines_cleared !== 5'd2) begin errors++; $display("FAIL two_lines got %0d want 2", lines_cleared); end
    bad = 0;
    for (int c = 0; c < 10; c++) if (mem[caddr(19, c)] !== ((c % 2 == 1) ? 8'h40 + 8'(c) : 8'h00)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL two_row19 got %0d bad cells want 0", bad); end
    bad = 0;
    for (int c = 0; c < 10; c++) if (mem[caddr(18, c)] !== ((c != 9) ? 8'h60 + 8'(c) : 8'h00)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL two_row18 got %0d bad cells want 0", bad); end
    checks++; if (mem[caddr(2, 5)] !== 8'd7) begin errors++; $display("FAIL two_shift_row2 got %0d want 7", mem[caddr(2, 5)]); end
    bad = 0;
    for (int c = 0; c < 10; c++) if (mem[caddr(0, c)] !== 8'd0 || mem[caddr(1, c)] !== 8'd0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL two_rows_0_1 got %0d bad cells want 0", bad); end
    checks++; if (we_cnt !== 200) begin errors++; $display("FAIL two_writes got %0d want 200", we_cnt); end
  endtask

  task automatic test_all_full();
    int cyc; bit tmo; bit b1; int bad;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    clear_img();
    for (int r = 0; r < 20; r++) fill_row(r);
    commit_img();
    run_op(cyc, tmo, b1);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL full_timeout got %0b want 0", tmo); end
    checks++; if (cyc !== 421) begin errors++; $display("FAIL full_latency got %0d want 421", cyc); end
    @(negedge clk);
    checks++; if (lines_cleared !== 5'd20) begin errors++; $display("FAIL full_lines got %0d want 20", lines_cleared); end
    bad = 0;
    for (int r = 0; r < 20; r++) for (int c = 0; c < 10; c++) if (mem[caddr(r, c)] !== 8'd0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_cells got %0d nonzero want 0", bad); end
    checks++; if (we_cnt !== 200) begin errors++; $display("FAIL full_writes got %0d want 200", we_cnt); end
    checks++; if (score !== EXP_FULL_SCORE) begin errors++; $display("FAIL full_score got %0d want %0d", score, EXP_FULL_SCORE); end
  endtask

  task automatic test_reset_mid_copy();
    int cyc; bit tmo; bit b1; bit seen;
    load_one_line();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (we) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL midrst_copy_seen got %0b want 1", seen); end
    rst = 1'b1;
    done_cnt = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b want 0", busy); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL midrst_we got %0b want 0", we); end
    checks++; if (addr !== 8'd0) begin errors++; $display("FAIL midrst_addr got %0d want 0", addr); end
    @(negedge clk); rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", done_cnt); end
    checks++; if (lines_cleared !== 5'd0) begin errors++; $display("FAIL midrst_lines got %0d want 0", lines_cleared); end
    load_one_line();
    run_op(cyc, tmo, b1);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL midrst_rerun_timeout got %0b want 0", tmo); end
    @(negedge clk);
    checks++; if (lines_cleared !== 5'd1) begin errors++; $display("FAIL midrst_rerun_lines got %0d want 1", lines_cleared); end
    checks++; if (mem[231] !== 8'd3) begin errors++; $display("FAIL midrst_rerun_cell got %0d want 3", mem[231]); end
  endtask

  task automatic test_start_while_busy();
    int cyc; bit tmo;
    clear_img();
    commit_img();
    @(negedge clk);
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    tmo = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (done) begin tmo = 1'b0; break; end
      @(negedge clk);
      cyc++;
      start = (cyc == 10);
    end
    start = 1'b0;
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL busy_start_timeout got %0b want 0", tmo); end
    checks++; if (cyc !== 221) begin errors++; $display("FAIL busy_start_latency got %0d want 221", cyc); end
    repeat (300) @(negedge clk);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_start_done_pulses got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %0b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_empty_grid();
    test_one_line();
    test_two_lines();
    test_all_full();
    test_reset_mid_copy();
    test_start_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
